// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a power-of-two transmit FIFO in front of the
// serializer. A new frame starts one edge after a byte lands in an empty FIFO.
// Frames queued behind each other go out with no idle gap between them.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle high, waiting for the FIFO to become non-empty
// START | start bit (io_tx=0) for one bit time
// DATA  | eight data bits, LSB first, io_tx follows shift[0]
// STOP  | stop bit (io_tx=1) for one bit time, then chain or go idle
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]    BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_empty;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never lets a full FIFO accept.
  assign tx_ready   = (fifo_count != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy       = (state != IDLE) || !fifo_empty;

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer; io_tx is registered and set on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      io_tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          io_tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            state    <= START;
            io_tx    <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            io_tx    <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              io_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              // shift[1] is what shift[0] becomes after this edge.
              io_tx   <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              state   <= START;
              io_tx   <= 1'b0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          io_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       io_tx;
  logic       busy;
  logic [3:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  logic       stim_valid [40];
  logic [7:0] stim_data  [40];

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .io_tx      (io_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 40; k++) begin
      stim_valid[k] = 1'b0;
      stim_data[k]  = 8'h00;
    end
  endtask

  // Checks one 40-cycle frame starting at the current sample point; after each
  // sample the per-cycle stimulus is applied for the following edge.
  task automatic frame(input logic [7:0] b);
    int   bi;
    logic eb;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick();
      bi = i / 4;
      if (bi == 0)      eb = 1'b0;
      else if (bi == 9) eb = 1'b1;
      else              eb = b[bi-1];
      chk($sformatf("frame_%02h_c%0d", b, i), io_tx, eb);
      chk($sformatf("busy_%02h_c%0d", b, i), busy, 1);
      tx_valid = stim_valid[i];
      tx_data  = stim_data[i];
    end
  endtask

  initial begin
    rstn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    clear_stim();
    repeat (3) tick();
    chk("rst_io_tx", io_tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);

    // byte offered on the first edge out of reset
    rstn = 1'b1; tx_valid = 1'b1; tx_data = 8'h96;
    tick();
    tx_valid = 1'b0;
    chk("rel_count", fifo_count, 1);
    chk("rel_io_tx_before", io_tx, 1);
    tick();
    frame(8'h96);
    tick();
    chk("rel_idle_busy", busy, 0);

    // single byte 0x55, first low one edge after accept
    tx_valid = 1'b1; tx_data = 8'h55;
    tick();
    tx_valid = 1'b0;
    chk("single_count", fifo_count, 1);
    chk("single_io_tx_before", io_tx, 1);
    tick();
    frame(8'h55);
    tick();
    chk("single_busy_after", busy, 0);
    chk("single_io_tx_after", io_tx, 1);
    chk("single_count_after", fifo_count, 0);

    // back-to-back 0x00 then 0xFF
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    tx_data = 8'hFF;
    chk("b2b_count_a", fifo_count, 1);
    tick();
    tx_valid = 1'b0;
    chk("b2b_count_b", fifo_count, 1);
    frame(8'h00);
    tick();
    frame(8'hFF);
    tick();
    chk("b2b_busy_after", busy, 0);

    // push on the STOP-end pop with one byte queued
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick();
    tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0;
    clear_stim();
    stim_valid[39] = 1'b1;
    stim_data[39]  = 8'h7E;
    frame(8'h3C);
    tick();
    tx_valid = 1'b0;
    chk("simul_count", fifo_count, 1);
    clear_stim();
    frame(8'hC3);
    tick();
    frame(8'h7E);
    tick();
    chk("simul_busy_after", busy, 0);

    // full FIFO plus backpressure with changing data
    tx_valid = 1'b1; tx_data = 8'h01;
    tick();
    tx_data = 8'h02;
    tick();
    clear_stim();
    for (int k = 0; k < 40; k++) begin
      stim_valid[k] = 1'b1;
      stim_data[k]  = (k < 7) ? 8'(8'h03 + k) : 8'(8'hE0 + k);
    end
    frame(8'h01);
    chk("full_count", fifo_count, 8);
    chk("full_ready", tx_ready, 0);
    tick();
    chk("full_count_pop", fifo_count, 7);
    chk("full_ready_pop", tx_ready, 1);
    clear_stim();
    stim_valid[0] = 1'b1;
    stim_data[0]  = 8'h5A;
    frame(8'h02);
    clear_stim();
    for (int b = 3; b <= 9; b++) begin
      tick();
      frame(8'(b));
    end
    tick();
    frame(8'h5A);
    tick();
    chk("full_busy_after", busy, 0);
    chk("full_count_after", fifo_count, 0);

    // reset during DATA bit 3 of 0xA5 with three bytes queued
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    tx_data = 8'h11;
    tick();
    tx_data = 8'h22;
    tick();
    tx_data = 8'h33;
    tick();
    tx_valid = 1'b0;
    chk("rstmid_count", fifo_count, 3);
    repeat (15) tick();
    chk("rstmid_bit3", io_tx, 0);
    rstn = 1'b0;
    tick();
    chk("rstmid_io_tx", io_tx, 1);
    chk("rstmid_count0", fifo_count, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", tx_ready, 1);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick();
      chk($sformatf("rstmid_quiet_io_c%0d", k), io_tx, 1);
      chk($sformatf("rstmid_quiet_busy_c%0d", k), busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
